// File: rtl/looper_pkg.sv
// Shared looper definitions: sequencer state encoding, transport scan codes,
// default bar length and the loop-width clamp.
package looper_pkg;

  localparam int DEF_BEATS_PER_BAR = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_REC   = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  // Width keys 2..6 belong to the width controller; listed here to keep the map in one place
  localparam logic [8:0] KEY_2     = 9'h01E;
  localparam logic [8:0] KEY_3     = 9'h026;
  localparam logic [8:0] KEY_4     = 9'h025;
  localparam logic [8:0] KEY_5     = 9'h02E;
  localparam logic [8:0] KEY_6     = 9'h036;
  localparam logic [8:0] KEY_R     = 9'h02D;
  localparam logic [8:0] KEY_P     = 9'h04D;
  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_S     = 9'h01B;

  typedef struct packed {
    logic rec;
    logic play;
    logic pause;
    logic stop;
  } cmd_t;

  function automatic logic [2:0] clamp_width(input logic [2:0] w);
    if (w < 3'd2) return 3'd2;
    if (w > 3'd6) return 3'd6;
    return w;
  endfunction

endpackage

// File: rtl/key_cmd_decoder.sv
// Turns keyboard decoder events into one-hot transport command pulses (press only).
module key_cmd_decoder
  import looper_pkg::*;
(
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output cmd_t         cmd
);

  logic press;
  assign press = key_valid && key_down[last_change];

  always_comb begin
    cmd = '0;
    if (press) begin
      case (last_change)
        KEY_R:     cmd.rec   = 1'b1;
        KEY_P:     cmd.play  = 1'b1;
        KEY_SPACE: cmd.pause = 1'b1;
        KEY_S:     cmd.stop  = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Record/playback sequencer: steps one loop slot per beat tick and issues
// registered write/read strobes for the loop RAM and mixer.
module loop_sequencer
  import looper_pkg::*;
#(
  parameter int BEATS_PER_BAR = DEF_BEATS_PER_BAR,
  parameter int ADDR_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      key_down,
  input  logic [8:0]        last_change,
  input  logic              key_valid,
  input  logic              beat_tick,
  input  logic [2:0]        loop_width,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] loop_len,
  output logic              has_loop,
  output logic              wr_strobe,
  output logic              rd_strobe
);

  cmd_t cmd;

  key_cmd_decoder u_dec (
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .cmd         (cmd)
  );

  logic [ADDR_W-1:0] new_len;
  logic              at_end;

  assign new_len = ADDR_W'(clamp_width(loop_width)) * ADDR_W'(BEATS_PER_BAR);
  assign at_end  = (step == loop_len - ADDR_W'(1));

  // Command handling sits ahead of tick handling in every branch, so an
  // acting command always swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      step      <= '0;
      loop_len  <= ADDR_W'(3 * BEATS_PER_BAR);
      has_loop  <= 1'b0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (cmd.stop) begin
        state <= ST_IDLE;
        step  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd.rec) begin
              state    <= ST_ARMED;
              step     <= '0;
              loop_len <= new_len;
            end else if (cmd.play && has_loop) begin
              state <= ST_PLAY;
              step  <= '0;
            end
          end
          ST_ARMED: begin
            if (beat_tick) begin
              state     <= ST_REC;
              step      <= '0;
              wr_strobe <= 1'b1;
            end
          end
          ST_REC: begin
            if (beat_tick) begin
              if (at_end) begin
                state     <= ST_PLAY;
                step      <= '0;
                has_loop  <= 1'b1;
                rd_strobe <= 1'b1;
              end else begin
                step      <= step + ADDR_W'(1);
                wr_strobe <= 1'b1;
              end
            end
          end
          ST_PLAY, ST_PAUSE: begin
            if (cmd.rec) begin
              state    <= ST_ARMED;
              step     <= '0;
              loop_len <= new_len;
              has_loop <= 1'b0;
            end else if (state == ST_PLAY) begin
              if (cmd.pause) begin
                state <= ST_PAUSE;
              end else if (beat_tick) begin
                step      <= at_end ? '0 : step + ADDR_W'(1);
                rd_strobe <= 1'b1;
              end
            end else if (cmd.pause || cmd.play) begin
              state <= ST_PLAY;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed vector bench for loop_sequencer: a table of per-cycle inputs and
// expected outputs, followed by a hand-written long-recording / reset sequence.
module tb_loop_sequencer;

  localparam logic [8:0] KR  = 9'h02D;
  localparam logic [8:0] KP  = 9'h04D;
  localparam logic [8:0] KSP = 9'h029;
  localparam logic [8:0] KS  = 9'h01B;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         beat_tick = 1'b0;
  logic [2:0]   loop_width = 3'd3;
  logic [2:0]   state;
  logic [4:0]   step;
  logic [4:0]   loop_len;
  logic         has_loop;
  logic         wr_strobe;
  logic         rd_strobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_sequencer #(.BEATS_PER_BAR(4), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .beat_tick   (beat_tick),
    .loop_width  (loop_width),
    .state       (state),
    .step        (step),
    .loop_len    (loop_len),
    .has_loop    (has_loop),
    .wr_strobe   (wr_strobe),
    .rd_strobe   (rd_strobe)
  );

  typedef struct {
    logic       rst;
    logic       kv;
    logic       kd;
    logic [8:0] code;
    logic       tick;
    logic [2:0] w;
    logic [2:0] st;
    logic [4:0] stp;
    logic [4:0] len;
    logic       hl;
    logic       wr;
    logic       rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(int r, int kv, int kd, logic [8:0] code, int tick, int w,
                             int st, int stp, int len, int hl, int wr, int rd);
    vec_t x;
    x.rst = r[0]; x.kv = kv[0]; x.kd = kd[0]; x.code = code; x.tick = tick[0];
    x.w = w[2:0]; x.st = st[2:0]; x.stp = stp[4:0]; x.len = len[4:0];
    x.hl = hl[0]; x.wr = wr[0]; x.rd = rd[0];
    return x;
  endfunction

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic apply(input vec_t x, input string name);
    @(negedge clk);
    rst         = x.rst;
    key_valid   = x.kv;
    last_change = x.code;
    key_down    = '0;
    key_down[x.code] = x.kd;
    beat_tick   = x.tick;
    loop_width  = x.w;
    @(posedge clk);
    #1;
    checks++;
    if ({state, step, loop_len, has_loop, wr_strobe, rd_strobe} !==
        {x.st, x.stp, x.len, x.hl, x.wr, x.rd}) begin
      errors++;
      $display("FAIL %s: got st=%0d step=%0d len=%0d has=%0d wr=%0d rd=%0d, want st=%0d step=%0d len=%0d has=%0d wr=%0d rd=%0d",
               name, state, step, loop_len, has_loop, wr_strobe, rd_strobe,
               x.st, x.stp, x.len, x.hl, x.wr, x.rd);
    end
    checks++;
    if (wr_strobe && rd_strobe) begin
      errors++;
      $display("FAIL %s strobe_excl: got wr=1 rd=1, want at most one", name);
    end
  endtask

  initial begin
    // reset, idle ticks, P without a loop
    vt.push_back(v(1,0,0,9'h0,0,3, 0,0,12,0,0,0));
    vt.push_back(v(0,0,0,9'h0,1,3, 0,0,12,0,0,0));
    vt.push_back(v(0,0,0,9'h0,1,3, 0,0,12,0,0,0));
    vt.push_back(v(0,1,1,KP,0,3,   0,0,12,0,0,0));
    // record a 2-bar loop
    vt.push_back(v(0,1,1,KR,0,2,   1,0,8,0,0,0));
    vt.push_back(v(0,0,0,9'h0,1,2, 2,0,8,0,1,0));
    for (int i = 1; i <= 7; i++) vt.push_back(v(0,0,0,9'h0,1,2, 2,i,8,0,1,0));
    vt.push_back(v(0,0,0,9'h0,1,2, 3,0,8,1,0,1));
    vt.push_back(v(0,0,0,9'h0,0,2, 3,0,8,1,0,0));
    // playback wraps; width change mid-play leaves loop_len alone
    for (int i = 1; i <= 10; i++) vt.push_back(v(0,0,0,9'h0,1,(i >= 5) ? 6 : 2, 3,i%8,8,1,0,1));
    for (int i = 3; i <= 5; i++) vt.push_back(v(0,0,0,9'h0,1,6, 3,i,8,1,0,1));
    // pause holds step
    vt.push_back(v(0,1,1,KSP,0,6,  4,5,8,1,0,0));
    for (int i = 0; i < 3; i++) vt.push_back(v(0,0,0,9'h0,1,6, 4,5,8,1,0,0));
    vt.push_back(v(0,1,1,KSP,0,6,  3,5,8,1,0,0));
    vt.push_back(v(0,0,0,9'h0,1,6, 3,6,8,1,0,1));
    // re-record from PLAY, abort with S+tick at step 3
    vt.push_back(v(0,1,1,KR,0,2,   1,0,8,0,0,0));
    vt.push_back(v(0,0,0,9'h0,1,2, 2,0,8,0,1,0));
    for (int i = 1; i <= 3; i++) vt.push_back(v(0,0,0,9'h0,1,2, 2,i,8,0,1,0));
    vt.push_back(v(0,1,1,KS,1,2,   0,0,8,0,0,0));
    // releases do nothing
    vt.push_back(v(0,1,0,KR,0,2,   0,0,8,0,0,0));
    vt.push_back(v(0,1,0,KP,0,2,   0,0,8,0,0,0));
    vt.push_back(v(0,1,0,KS,0,2,   0,0,8,0,0,0));
    // width above range clamps to 6 bars
    vt.push_back(v(0,1,1,KR,0,7,   1,0,24,0,0,0));

    foreach (vt[i]) apply(vt[i], $sformatf("row%0d", i));

    // full 24-slot recording into PLAY
    apply(v(0,0,0,9'h0,1,7, 2,0,24,0,1,0), "rec24_first");
    for (int i = 1; i <= 23; i++) apply(v(0,0,0,9'h0,1,7, 2,i,24,0,1,0), $sformatf("rec24_s%0d", i));
    apply(v(0,0,0,9'h0,1,7, 3,0,24,1,0,1), "rec24_wrap");
    // R from PLAY with width 0 clamps to 2 bars and clears has_loop
    apply(v(0,1,1,KR,0,0,   1,0,8,0,0,0), "rerec_w0");
    apply(v(0,0,0,9'h0,1,0, 2,0,8,0,1,0), "rerec_t0");
    apply(v(0,0,0,9'h0,1,0, 2,1,8,0,1,0), "rerec_t1");
    // reset overrides coincident command and tick
    apply(v(1,1,1,KS,1,5,   0,0,12,0,0,0), "rst_mid_rec");
    apply(v(0,0,0,9'h0,0,5, 0,0,12,0,0,0), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
Sequences the looper's record/playback pass over the loop memory, stepping one slot per beat tick. Decodes keyboard transport commands (R record, P play, Space pause, S stop) from the shared keyboard decoder. Latches the loop length from loop_width (bars, range 2..6) when a recording is armed. Drives the step address and the write/read strobes for the loop RAM and the sound mixer.

Parameters:
BEATS_PER_BAR, 4, beat slots per bar; loop length = width * BEATS_PER_BAR.
ADDR_W, 5, step/address width; must hold 6*BEATS_PER_BAR-1 (23 at default).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_down  in  512  keyboard level state per scan code
last_change  in  9  scan code of most recent key event
key_valid  in  1  one-cycle pulse: last_change updated
beat_tick  in  1  one-cycle pulse at tempo rate
loop_width  in  3  bars per loop from the width controller, nominal 2..6
state  out  3  0 IDLE, 1 ARMED, 2 RECORD, 3 PLAY, 4 PAUSE
step  out  ADDR_W  current loop slot
loop_len  out  ADDR_W  latched loop length in slots
has_loop  out  1  a complete loop has been recorded
wr_strobe  out  1  one-cycle write enable for slot step
rd_strobe  out  1  one-cycle read enable for slot step

Behaviour:
- Reset (sync, clk edge with rst=1): state=IDLE, step=0, loop_len=3*BEATS_PER_BAR (12), has_loop=0, wr_strobe=0, rd_strobe=0.
- A command is valid only when key_valid && key_down[last_change], i.e. on press, never on release. Codes: R=9'h02D, P=9'h04D, Space=9'h029, S=9'h01B. All other codes are ignored.
- Width clamp: loop_width<2 maps to 2 and loop_width>6 maps to 6. loop_len = clamped * BEATS_PER_BAR, latched only on entry to ARMED.
- Transitions. Commands are evaluated before beat_tick in the same cycle.
  - IDLE: R goes to ARMED and latches loop_len. P with has_loop=1 goes to PLAY with step=0. P with has_loop=0 is ignored.
  - ARMED: beat_tick goes to RECORD with step=0, and asserts wr_strobe next cycle for slot 0.
  - RECORD: each beat_tick produces step+1 with a wr_strobe. On the tick with step==loop_len-1: step wraps to 0, has_loop=1, state goes to PLAY, and rd_strobe is asserted for slot 0. That tick does not produce a wr_strobe.
  - PLAY: each beat_tick produces step = (step==loop_len-1) ? 0 : step+1, with an rd_strobe for the new step. Space goes to PAUSE.
  - PAUSE: step is held and no strobes are issued. Space or P goes to PLAY. The step is unchanged, and advance resumes on the next tick.
  - S in any state goes to IDLE with step=0. has_loop and loop_len are kept.
  - R in PLAY or PAUSE goes to ARMED: re-latches loop_len and clears has_loop. R in ARMED or RECORD is ignored.
- Same-cycle command and beat_tick: the command transition wins and the tick is dropped.
  - Example: S and tick together in RECORD gives IDLE with no strobe.
  - A partial recording aborted by S leaves has_loop=0 if no loop was completed before.
- Strobes are registered, one cycle after the consuming beat_tick. step already holds the addressed slot in the strobe cycle. wr_strobe and rd_strobe are never high together.
- loop_width changes outside ARMED entry have no effect on loop_len.
- Reset during any state overrides all other inputs.

Decomposition:
- Shared package (looper_pkg):
  - state encoding constants IDLE..PAUSE;
  - scan-code constants KEY_R, KEY_P, KEY_SPACE, KEY_S, next to the width keys 2..6 already used by the width controller;
  - BEATS_PER_BAR default.
- One natural sub-module, key_cmd_decoder. It maps key_valid/key_down/last_change to one-hot cmd pulses {rec, play, pause, stop}. The FSM, step counter and strobes stay in loop_sequencer.

Test Plan:
1. Reset then idle ticks -> state=0, step=0, loop_len=12, has_loop=0, no strobes. P press in IDLE -> ignored.
2. loop_width=2, R press, then 9 beat_ticks:
   - ARMED, then RECORD;
   - wr_strobe at steps 0..7 (8 strobes);
   - on the 9th tick: PLAY, step=0, rd_strobe, has_loop=1, loop_len=8.
3. In PLAY with loop_len=8, 10 ticks -> rd_strobe on steps 1..7, 0, 1, 2. Raise loop_width to 6 mid-play -> loop_len stays 8.
4. PLAY at step 5, Space -> PAUSE. 3 ticks -> step stays 5, no strobes. Space, then 1 tick -> PLAY, step=6, rd_strobe.
5. RECORD at step 3, S and beat_tick in the same cycle -> IDLE, step=0, no wr_strobe. Release events (key_down=0) for R/P/S -> no state change.
6. loop_width=7, R -> loop_len=24. loop_width=0 on next R from PLAY -> loop_len=8 and has_loop cleared. rst asserted mid-RECORD -> all outputs at reset values next cycle.
